// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage RISC-V core. This file has no ports.
// It holds:
//   - opcode constants used by the decoder and the hazard logic
//   - the MUL funct7 code
//   - the encoding of the multiplier sequencing FSM states
//   - the default multiplier latency
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_ALU_R     = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] OPC_JUMP      = 7'b1101111;

    // An R-type instruction with this funct7 is a MUL
    localparam logic [6:0] FUNCT7_MUL    = 7'b0000001;

    // Number of cycles a MUL occupies EX (legal range 2..8)
    localparam int DEFAULT_MUL_LATENCY = 3;

    // Multiplier sequencing states
    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } mul_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
// Bundle of the signals between the pipeline and the hazard controller.
// Pipeline -> controller:
//   id_rs1, id_rs2, id_uses_rs1, id_uses_rs2  : sources of the ID instruction
//   ex_mem_read, ex_rd, ex_is_mul             : the EX instruction
//   mem_branch_taken                          : branch in MEM resolved taken
// Controller -> pipeline:
//   pc_write, if_id_write, id_ex_write        : register enables
//   if_id_flush, id_ex_flush, ex_mem_flush    : bubble insertion
//   mul_start, mul_busy                       : multiplier control/status
// The pipeline side uses the master modport, the controller the slave one.
// ---------------------------------------------------------------------------
interface hazard_controller_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_is_mul;
    logic       mem_branch_taken;

    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mul_start;
    logic       mul_busy;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, ex_is_mul, mem_branch_taken,
        input  pc_write, if_id_write, id_ex_write,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mul_start, mul_busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_rd, ex_is_mul, mem_branch_taken,
        output pc_write, if_id_write, id_ex_write,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mul_start, mul_busy
    );

endinterface

// File: rtl/hazard_controller_mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq_fsm
// Holds a MUL in EX for MUL_LATENCY cycles.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   flush      : taken branch in MEM, aborts any sequence
//   ex_is_mul  : the EX instruction is a MUL
//   mul_start  : one-cycle pulse starting the multiplier
//   mul_busy   : multiplier mid-operation
//   mul_stall  : freeze PC/IF/ID/EX and bubble EX/MEM this cycle
//   in_idle    : FSM is in IDLE (load-use detection is allowed)
// ---------------------------------------------------------------------------
module mul_seq_fsm
    import cpu_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic ex_is_mul,
    output logic mul_start,
    output logic mul_busy,
    output logic mul_stall,
    output logic in_idle
);

    // The start cycle is one stall cycle, so the counter covers the rest
    localparam logic [2:0] CNT_LOAD = 3'(MUL_LATENCY - 2);

    mul_state_t state;
    mul_state_t next_state;
    logic [2:0] cnt;
    logic [2:0] next_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Outputs are forced to idle values during reset so mul_busy drops
    // in the same cycle rst rises, not one edge later.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        mul_start  = 1'b0;
        mul_busy   = 1'b0;
        mul_stall  = 1'b0;
        in_idle    = (state == IDLE);
        if (rst) begin
            next_state = IDLE;
            next_cnt   = 3'd0;
        end else if (flush) begin
            next_state = IDLE;
            next_cnt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_is_mul) begin
                        mul_start  = 1'b1;
                        mul_busy   = 1'b1;
                        mul_stall  = 1'b1;
                        next_cnt   = CNT_LOAD;
                        next_state = MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (cnt != 3'd0) begin
                        mul_busy  = 1'b1;
                        mul_stall = 1'b1;
                        next_cnt  = cnt - 3'd1;
                    end else begin
                        // Product is ready; EX advances so the MUL leaves
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard and sequencing controller: branch flush, multi-cycle MUL
// hold and load-use stall, in that priority order.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : hazard_controller_if slave (pipeline inputs, control outputs)
// ---------------------------------------------------------------------------
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  bus
);

    logic mul_start;
    logic mul_busy;
    logic mul_stall;
    logic in_idle;
    logic load_use;

    mul_seq_fsm #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_seq (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.mem_branch_taken),
        .ex_is_mul (bus.ex_is_mul),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .mul_stall (mul_stall),
        .in_idle   (in_idle)
    );

    // A load writing x0 never creates a dependency
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                       (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    // Priority mux: flush, then MUL hold, then load-use. The load-use bubble
    // keeps id_ex_write high so the flushed bubble is actually loaded.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mul_start    = mul_start;
        bus.mul_busy     = mul_busy;
        if (rst) begin
            bus.mul_start = 1'b0;
            bus.mul_busy  = 1'b0;
        end else if (bus.mem_branch_taken) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b1;
        end else if (mul_stall) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_flush = 1'b1;
        end else if (in_idle && !bus.ex_is_mul && load_use) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Directed scoreboard bench for hazard_controller with MUL_LATENCY 3 and 5.
// Output vector order: pc_write, if_id_write, id_ex_write, if_id_flush,
// id_ex_flush, ex_mem_flush, mul_start, mul_busy.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

    localparam logic [7:0] NORM   = 8'b11100000;
    localparam logic [7:0] LU     = 8'b00101000;
    localparam logic [7:0] MSTART = 8'b00000111;
    localparam logic [7:0] MBUSY  = 8'b00000101;
    localparam logic [7:0] BR     = 8'b11111100;

    typedef struct {
        int         step;
        logic [7:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t q3[$];
    exp_t q5[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    hazard_controller_if if3 ();
    hazard_controller_if if5 ();

    hazard_controller #(.MUL_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    hazard_controller #(.MUL_LATENCY(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    always #5 clk = ~clk;

    function automatic logic [7:0] pack3();
        return {if3.pc_write, if3.if_id_write, if3.id_ex_write, if3.if_id_flush,
                if3.id_ex_flush, if3.ex_mem_flush, if3.mul_start, if3.mul_busy};
    endfunction

    function automatic logic [7:0] pack5();
        return {if5.pc_write, if5.if_id_write, if5.id_ex_write, if5.if_id_flush,
                if5.id_ex_flush, if5.ex_mem_flush, if5.mul_start, if5.mul_busy};
    endfunction

    // Drive one cycle on the selected DUT (0: latency 3, 1: latency 5); the
    // other DUT sees an idle pipeline and must show default outputs.
    task automatic applyStimulus(input bit which, input logic r,
                                 input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic mul, input logic br,
                                 input logic [7:0] exp);
        exp_t e3;
        exp_t e5;
        @(posedge clk);
        #1;
        step = step + 1;
        rst = r;
        if3.ex_mem_read = which ? 1'b0 : mr;
        if3.ex_rd       = which ? 5'd0 : rd;
        if3.id_rs1      = which ? 5'd0 : rs1;
        if3.id_uses_rs1 = which ? 1'b0 : u1;
        if3.id_rs2      = which ? 5'd0 : rs2;
        if3.id_uses_rs2 = which ? 1'b0 : u2;
        if3.ex_is_mul   = which ? 1'b0 : mul;
        if3.mem_branch_taken = which ? 1'b0 : br;
        if5.ex_mem_read = which ? mr : 1'b0;
        if5.ex_rd       = which ? rd : 5'd0;
        if5.id_rs1      = which ? rs1 : 5'd0;
        if5.id_uses_rs1 = which ? u1 : 1'b0;
        if5.id_rs2      = which ? rs2 : 5'd0;
        if5.id_uses_rs2 = which ? u2 : 1'b0;
        if5.ex_is_mul   = which ? mul : 1'b0;
        if5.mem_branch_taken = which ? br : 1'b0;
        e3.step = step;
        e5.step = step;
        e3.exp  = which ? NORM : exp;
        e5.exp  = which ? exp : NORM;
        q3.push_back(e3);
        q5.push_back(e5);
    endtask

    // Monitor: sample combinational outputs mid-cycle and compare against
    // the oldest pending expectation of each DUT.
    task automatic checkOutput();
        exp_t e;
        logic [7:0] got;
        if (q3.size() > 0) begin
            e = q3.pop_front();
            got = pack3();
            checks = checks + 1;
            if (got !== e.exp) begin
                errors = errors + 1;
                $display("[TB] FAIL lat3 step %0d: got %b expected %b", e.step, got, e.exp);
            end
        end
        if (q5.size() > 0) begin
            e = q5.pop_front();
            got = pack5();
            checks = checks + 1;
            if (got !== e.exp) begin
                errors = errors + 1;
                $display("[TB] FAIL lat5 step %0d: got %b expected %b", e.step, got, e.exp);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        // Reset with hostile inputs: outputs must stay at defaults
        applyStimulus(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 1, NORM);
        applyStimulus(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> one bubble
        applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd1, 1, 0, 0, LU);
        applyStimulus(0, 0, 0, 5'd6, 5'd5, 1, 5'd1, 1, 0, 0, NORM);
        // Load to x0: no hazard
        applyStimulus(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, NORM);
        // Match on rs2 only
        applyStimulus(0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, LU);
        // Register matches but is not read
        applyStimulus(0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 0, 0, 0, NORM);
        // Match but EX is not a load
        applyStimulus(0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, NORM);

        // Single MUL, latency 3
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Back-to-back MULs: starts three cycles apart, no gap
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Load in EX with MUL in ID: stall once, then the MUL runs
        applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, LU);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        // Release cycle of a MUL_RUN: load-use is not evaluated
        applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Taken branch with a MUL in EX: flush, no start, stay IDLE
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, BR);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);
        // Taken branch wins over load-use
        applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, BR);

        // Branch during MUL_RUN aborts to IDLE (a new MUL starts at once)
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, BR);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Reset at t+1 of a MUL: defaults while rst, IDLE after release
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);

        // Latency 5: back-to-back MULs, four stall cycles each
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MSTART);
            for (int j = 0; j < 3; j++)
                applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, MBUSY);
            applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, NORM);
        end
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, NORM);
        // Latency 5: load-use still one bubble
        applyStimulus(1, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, LU);
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0, NORM);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && (q3.size() > 0 || q5.size() > 0); i++)
            @(posedge clk);
        @(posedge clk);
        if (q3.size() > 0 || q5.size() > 0) begin
            errors = errors + 1;
            $display("[TB] FAIL drain: %0d/%0d entries left, required 0", q3.size(), q5.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
